// File: rtl/booth_multiple_gen.sv
// ---------------------------------------------------------------------------
// booth_multiple_gen
//
// Two-stage pipelined generator of the radix-8 MBE multiplicand multiples
// {1x, 2x, 3x, 4x} for the partial-product selectors. 1x, 2x and 4x are plain
// wiring on the extended operand. 3x needs a real carry chain, which is split:
// stage 1 adds the low SPLIT bits and registers the carry, and stage 2 finishes
// the upper slice. This keeps the full-width 3x adder out of any single cycle.
//
// Parameters
//   WIDTH   multiplicand width (>= 4)
//   SIGNED  0: zero-extend multiples, 1: sign-extend (two's complement x_in)
//   SPLIT   width of the low 3x slice added in stage 1 (1..WIDTH-1)
//
// Ports
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous active-low reset
//   in_valid   in   1          x_in is valid
//   in_ready   out  1          block accepts x_in this cycle
//   x_in       in   WIDTH      multiplicand
//   out_valid  out  1          x_1..x_4 are valid
//   out_ready  in   1          consumer takes the outputs this cycle
//   x_1..x_4   out  WIDTH+3    1x, 2x, 3x, 4x of the extended multiplicand
// ---------------------------------------------------------------------------
module booth_multiple_gen #(
    parameter int WIDTH  = 24,
    parameter bit SIGNED = 1'b0,
    parameter int SPLIT  = WIDTH / 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH+2:0]   x_1,
    output logic [WIDTH+2:0]   x_2,
    output logic [WIDTH+2:0]   x_3,
    output logic [WIDTH+2:0]   x_4
);

    localparam int XW = WIDTH + 3;    // width of every multiple
    localparam int HW = XW - SPLIT;   // width of the upper 3x slice

    // Stage 1 state
    logic              s1_valid;
    logic [XW-1:0]     s1_ext;
    logic [SPLIT:0]    s1_lo;         // low 3x slice, MSB is the carry into the upper slice

    // Handshake
    logic              s2_adv;
    logic              s1_adv;
    logic              accept;

    // Stage 1 combinational inputs
    logic [XW-1:0]     ext_in;
    logic [SPLIT-1:0]  dbl_lo_in;     // low SPLIT bits of 2*x_in
    logic [SPLIT:0]    lo_in;

    // Stage 2 combinational
    logic [HW-1:0]     hi_sum;

    // A slot moves forward when the output register is empty or being
    // emptied; in_ready never looks at in_valid, so there is no
    // combinational in->out path.
    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_adv;
    assign in_ready = !s1_valid || s2_adv;
    assign accept   = in_valid && in_ready;

    // Low SPLIT bits of {x_in, 1'b0}; with SPLIT == 1 this is just the shifted-in zero.
    generate
        if (SPLIT == 1) begin : g_dbl_lo_one
            assign dbl_lo_in = 1'b0;
        end else begin : g_dbl_lo_wide
            assign dbl_lo_in = {x_in[SPLIT-2:0], 1'b0};
        end
    endgenerate

    // NOTE: every variable written here gets a value on every path, so no latch is inferred.
    always_comb begin
        ext_in = SIGNED ? {{3{x_in[WIDTH-1]}}, x_in} : {3'b000, x_in};
        lo_in  = {1'b0, x_in[SPLIT-1:0]} + {1'b0, dbl_lo_in};
        // Upper slice of ext + (ext << 1) plus the stage-1 carry, truncated to HW bits.
        // (ext << 1)[XW-1:SPLIT] is ext[XW-2:SPLIT-1].
        hi_sum = s1_ext[XW-1:SPLIT] + s1_ext[XW-2:SPLIT-1]
               + {{(HW-1){1'b0}}, s1_lo[SPLIT]};
    end

    // Stage 1: capture the extended operand and the low 3x slice at accept.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            // NOTE: data registers are reset too, so a stage never exposes stale or X data after reset.
            s1_ext   <= '0;
            s1_lo    <= '0;
        end else begin
            // When in_ready is high, S1 is either empty or handing its entry on.
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (accept) begin
                s1_ext <= ext_in;
                s1_lo  <= lo_in;
            end
        end
    end

    // Stage 2: output registers. They hold bit-stable during a stall and keep
    // their last value after a drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            x_1       <= '0;
            x_2       <= '0;
            x_3       <= '0;
            x_4       <= '0;
        end else begin
            if (s2_adv) begin
                out_valid <= s1_valid;
            end
            if (s1_adv) begin
                x_1 <= s1_ext;
                x_2 <= {s1_ext[XW-2:0], 1'b0};
                x_3 <= {hi_sum, s1_lo[SPLIT-1:0]};
                x_4 <= {s1_ext[XW-3:0], 2'b00};
            end
        end
    end

endmodule

// File: tb/tb_booth_multiple_gen.sv
// ---------------------------------------------------------------------------
// tb_booth_multiple_gen
//
// Bench for booth_multiple_gen (WIDTH=24, SPLIT=12). An unsigned and a signed
// instance share every input, so their handshakes are identical and one
// scoreboard queue of accepted operands serves both; each instance's expected
// multiples come from plain multiplication of the extended operand.
// ---------------------------------------------------------------------------
module tb_booth_multiple_gen;

    localparam int W  = 24;
    localparam int XW = W + 3;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [W-1:0]  x_in;
    logic          out_ready;

    logic          u_in_ready, s_in_ready;
    logic          u_out_valid, s_out_valid;
    logic [XW-1:0] u_x1, u_x2, u_x3, u_x4;
    logic [XW-1:0] s_x1, s_x2, s_x3, s_x4;

    logic [4*XW-1:0] u_pack, s_pack;
    assign u_pack = {u_x1, u_x2, u_x3, u_x4};
    assign s_pack = {s_x1, s_x2, s_x3, s_x4};

    booth_multiple_gen #(.WIDTH(W), .SIGNED(1'b0), .SPLIT(12)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u_in_ready),
        .x_in(x_in), .out_valid(u_out_valid), .out_ready(out_ready),
        .x_1(u_x1), .x_2(u_x2), .x_3(u_x3), .x_4(u_x4)
    );

    booth_multiple_gen #(.WIDTH(W), .SIGNED(1'b1), .SPLIT(12)) s_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .x_in(x_in), .out_valid(s_out_valid), .out_ready(out_ready),
        .x_1(s_x1), .x_2(s_x2), .x_3(s_x3), .x_4(s_x4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int              n_cmp = 0;
    int              n_err = 0;
    int              n_in  = 0;
    int              n_out = 0;
    logic [W-1:0]    sb[$];
    bit              prev_stall = 1'b0;
    logic [4*XW-1:0] prev_u, prev_s;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // k times the WIDTH+3-bit extension of x, modulo 2^(WIDTH+3).
    function automatic logic [XW-1:0] mult(input logic [W-1:0] x, input bit sgn, input int k);
        logic [XW-1:0] e;
        logic [XW-1:0] kk;
        e  = sgn ? {{3{x[W-1]}}, x} : {3'b000, x};
        kk = k[XW-1:0];
        return e * kk;
    endfunction

    // One clock cycle. Inputs are already driven (just after an edge); outputs
    // are checked 1 time unit later, well away from the next rising edge.
    task automatic cycle(output bit acc);
        logic [W-1:0] x;
        logic [W-1:0] acc_x;
        #1;
        acc   = in_valid && u_in_ready;
        acc_x = x_in;
        check("valid_match", s_out_valid, u_out_valid);
        check("ready_match", s_in_ready, u_in_ready);
        if (prev_stall) begin
            check("stall_valid", u_out_valid, 1);
            check("stall_hold_u", u_pack, prev_u);
            check("stall_hold_s", s_pack, prev_s);
        end
        if (u_out_valid && out_ready) begin
            check("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                x = sb.pop_front();
                check("u_x1", u_x1, mult(x, 1'b0, 1));
                check("u_x2", u_x2, mult(x, 1'b0, 2));
                check("u_x3", u_x3, mult(x, 1'b0, 3));
                check("u_x4", u_x4, mult(x, 1'b0, 4));
                check("s_x1", s_x1, mult(x, 1'b1, 1));
                check("s_x2", s_x2, mult(x, 1'b1, 2));
                check("s_x3", s_x3, mult(x, 1'b1, 3));
                check("s_x4", s_x4, mult(x, 1'b1, 4));
            end
            n_out++;
        end
        prev_stall = u_out_valid && !out_ready;
        prev_u     = u_pack;
        prev_s     = s_pack;
        @(posedge clk);
        #1;
        if (acc) begin
            sb.push_back(acc_x);
            n_in++;
        end
    endtask

    // Single operand through an empty pipeline: accept, one cycle in S1,
    // visible after the second edge, then drained.
    task automatic one_shot(input logic [W-1:0] x);
        bit a;
        in_valid  = 1'b1;
        x_in      = x;
        out_ready = 1'b1;
        cycle(a);
        check("os_accept", a, 1);
        in_valid = 1'b0;
        check("os_lat_s1", u_out_valid, 0);
        cycle(a);
        check("os_lat_out", u_out_valid, 1);
        cycle(a);
        check("os_drain", u_out_valid, 0);
    endtask

    task automatic drain();
        bit a;
        int guard;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard     = 0;
        while ((sb.size() != 0 || u_out_valid) && guard < 50) begin
            cycle(a);
            guard++;
        end
        check("drain_sb_empty", sb.size(), 0);
        check("drain_valid_low", u_out_valid, 0);
    endtask

    logic [W-1:0] ops [5];
    int           base_out;
    int           base_in;
    int           idx;
    int           guard;
    bit           a;
    int           sel;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        x_in      = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", u_out_valid, 0);
        check("rst_u_data", u_pack, 0);
        check("rst_s_data", s_pack, 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", u_in_ready, 1);

        // Full-scale unsigned operand.
        one_shot(24'hFFFFFF);
        check("t1_x1", u_x1, 27'h0FFFFFF);
        check("t1_x2", u_x2, 27'h1FFFFFE);
        check("t1_x3", u_x3, 27'h2FFFFFD);
        check("t1_x4", u_x4, 27'h3FFFFFC);

        // Carry out of the low 3x slice, and none.
        one_shot(24'h000FFF);
        check("t2_carry_x3", u_x3, 27'h0002FFD);
        one_shot(24'h000800);
        check("t2_nocarry_x3", u_x3, 27'h0001800);

        // Most negative signed operand.
        one_shot(24'h800000);
        check("t3_s_x1", s_x1, 27'h7800000);
        check("t3_s_x2", s_x2, 27'h7000000);
        check("t3_s_x3", s_x3, 27'h6800000);
        check("t3_s_x4", s_x4, 27'h6000000);
        check("t3_u_x3", u_x3, 27'h1800000);

        // Backpressure: 5 back-to-back operands, out_ready low for 3 cycles.
        for (int i = 0; i < 5; i++) ops[i] = W'($urandom);
        base_out  = n_out;
        base_in   = n_in;
        idx       = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            x_in = ops[idx];
            cycle(a);
            if (a) idx++;
            check("bp_accept", a, (c < 2) ? 1 : 0);
        end
        out_ready = 1'b1;
        guard     = 0;
        while (idx < 5 && guard < 20) begin
            x_in = ops[idx];
            cycle(a);
            if (a) idx++;
            guard++;
        end
        check("bp_all_accepted", idx, 5);
        drain();
        check("bp_in_count", n_in - base_in, 5);
        check("bp_out_count", n_out - base_out, 5);

        // Full rate: 100 cycles with in_valid and out_ready held high.
        base_out  = n_out;
        base_in   = n_in;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            x_in = W'($urandom);
            cycle(a);
        end
        check("rate_in_count", n_in - base_in, 100);
        check("rate_out_count", n_out - base_out, 98);
        drain();

        // Random streaming: 1000 operands, random valid/ready, corner values mixed in.
        base_in = n_in;
        guard   = 0;
        while (n_in - base_in < 1000 && guard < 20000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            sel       = $urandom_range(0, 7);
            case (sel)
                0:       x_in = '0;
                1:       x_in = '1;
                2:       x_in = 24'h800000;
                3:       x_in = 24'h7FFFFF;
                default: x_in = W'($urandom);
            endcase
            cycle(a);
            guard++;
        end
        check("rand_in_count", n_in - base_in, 1000);
        drain();

        // Reset with both stages full: everything in flight is discarded.
        in_valid  = 1'b1;
        out_ready = 1'b0;
        x_in      = 24'h123456;
        cycle(a);
        x_in = 24'hABCDEF;
        cycle(a);
        check("rs_out_valid_before", u_out_valid, 1);
        check("rs_s1_full", u_in_ready, 0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rs_out_valid_async", u_out_valid, 0);
        check("rs_s_out_valid_async", s_out_valid, 0);
        check("rs_u_data", u_pack, 0);
        check("rs_s_data", s_pack, 0);
        sb.delete();
        prev_stall = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle(a);
            check("rs_no_ghost", u_out_valid, 0);
        end
        one_shot(24'h5A5A5A);
        check("rs_first_x3", u_x3, 27'h10F0F0E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
